weight_update_engine: RTL
=========================

Name: weight_update_engine

Overview:
- Sequential, parametrised output-layer back-propagation engine for the drowsiness-detector neural network.
- On `start` it captures the actual outputs, the calculated outputs and the hidden-layer outputs.
- It computes a per-neuron error delta, then walks all N_OUT x N_HID output-layer weights in the shared weight RAM: read, update with learning-rate scaling and saturation, write back.
- It sits between the hidden/output layer evaluation and the WeightRAM, and replaces the fixed 3x5 combinational update path.

Parameters:
- N_OUT, 3, number of output neurons
- N_HID, 5, number of hidden neurons (weights per output neuron)
- DW, 10, data/weight width; activations unsigned Q0.DW (value/2^DW), weights signed two's complement
- ADDR_W, 7, weight RAM address width
- BASE_ADDR, 50, RAM address of weight[0][0]
- LR_SHIFT, 3, learning rate = 2^-LR_SHIFT

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Rst  in  1  reset, synchronous, active-low
- start  in  1  request an update pass; honoured only in IDLE
- out_actual  in  N_OUT*DW  target outputs, neuron k at bits [k*DW +: DW]
- out_cal  in  N_OUT*DW  calculated output-layer outputs
- hid_cal  in  N_HID*DW  calculated hidden-layer outputs
- ram_addr  out  ADDR_W  weight RAM address
- ram_we  out  1  weight RAM write enable
- ram_wdata  out  DW  updated weight (signed)
- ram_rdata  in  DW  weight RAM read data; valid one cycle after ram_addr is presented with ram_we=0
- delta_out  out  N_OUT*DW  delta magnitudes of the last pass
- delta_sign  out  N_OUT  1 = target below calculated (weights decrease)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass

Behaviour:
Reset (Rst=0 at clock edge):
- State goes to IDLE.
- ram_we, busy, done, ram_addr, ram_wdata, delta_out and delta_sign all go to 0.
- Reset mid-pass aborts immediately; no further writes occur; weights already written stay written.

Input capture:
- `start` sampled high in IDLE latches out_actual, out_cal and hid_cal into internal registers, then moves to DELTA.
- Inputs may change freely after capture.
- `start` while busy is ignored and is not queued.

States:
- IDLE -> DELTA on start.
- DELTA (1 cycle): for each k compute:
  - err = |actual - cal|; sign = (actual < cal)
  - sp = (cal * (2^DW - cal)) >> DW
  - delta = (err * sp) >> DW
  - Register delta_out and delta_sign; k=j=0; go to READ.
- READ: ram_addr = (BASE_ADDR + k*N_HID + j) mod 2^ADDR_W, ram_we=0. Go to WAIT.
- WAIT: capture ram_rdata as w. Go to WRITE.
- WRITE:
  - g = ((delta[k] * hid_cal[j]) >> DW) >> LR_SHIFT, as unsigned
  - w_new = w + g if sign=0, w - g if sign=1, computed at DW+2 bits
  - Saturate w_new to [-2^(DW-1), 2^(DW-1)-1]
  - ram_we=1 for this single cycle, same ram_addr, ram_wdata = w_new
  - Advance j; on j = N_HID-1 reset j to 0 and advance k
  - Go to READ, or to DONE after the last weight
- DONE: done=1 and busy=1 for one cycle. Go to IDLE.

Timing and outputs:
- Latency from the start edge to the done pulse is 2 + 3*N_OUT*N_HID cycles; defaults give 47.
- ram_we is high only in WRITE; each address is written exactly once per pass, in order k-major, j-minor.
- delta_out and delta_sign hold their values until the next DELTA state.

Boundary cases:
- err = 0, cal = 0, or cal = max: delta may be 0. Weights are still rewritten, unchanged.

Test Plan:
- Defaults; actual0=768, cal0=512, all hid=512, RAM[50..54]=100 -> delta_out[0]=64, delta_sign[0]=0, RAM[50..54]=104, done at cycle 47.
- actual1=256, cal1=512, hid=512, RAM[55]=-510 -> delta_sign[1]=1, RAM[55]=-512 (saturated, not -514).
- actual0=768, cal0=512, hid=512, RAM[50]=510 -> RAM[50]=511 (positive saturation).
- actual==cal for all k -> delta_out=0, 15 write cycles observed, all RAM contents unchanged, done pulse one cycle wide.
- start pulsed again at cycle 10 of a pass -> ignored; exactly 15 writes; single done at cycle 47.
- Rst=0 at cycle 20 -> next cycle busy=0, ram_we=0, no further writes; RAM[50..55] updated, RAM[56..64] untouched.

Source files
------------

// File: rtl/weight_update_engine.sv
// Output-layer back-propagation engine: captures one training sample, derives
// a per-neuron error delta, then read-modify-writes every output-layer weight
// in the shared weight RAM with learning-rate scaling and saturation.
module weight_update_engine #(
    parameter int unsigned N_OUT     = 3,
    parameter int unsigned N_HID     = 5,
    parameter int unsigned DW        = 10,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BASE_ADDR = 50,
    parameter int unsigned LR_SHIFT  = 3
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [N_OUT*DW-1:0]   out_actual,
    input  logic [N_OUT*DW-1:0]   out_cal,
    input  logic [N_HID*DW-1:0]   hid_cal,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [DW-1:0]         ram_wdata,
    input  logic [DW-1:0]         ram_rdata,
    output logic [N_OUT*DW-1:0]   delta_out,
    output logic [N_OUT-1:0]      delta_sign,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned JW = (N_HID > 1) ? $clog2(N_HID) : 1;

    localparam logic signed [DW+1:0] SAT_HI = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SAT_LO = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELTA,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DW-1:0]   act_r   [N_OUT];
    logic [DW-1:0]   cal_r   [N_OUT];
    logic [DW-1:0]   hid_r   [N_HID];
    logic [DW-1:0]   delta_r [N_OUT];
    logic [DW-1:0]   delta_nxt [N_OUT];
    logic [N_OUT-1:0] sign_nxt;

    logic [KW-1:0]   k;
    logic [JW-1:0]   j;
    logic [DW-1:0]   w;
    logic            last_weight;

    logic [31:0]             addr_full;
    logic [2*DW-1:0]         g_prod;
    logic [DW-1:0]           g;
    logic signed [DW+1:0]    w_ext;
    logic signed [DW+1:0]    g_ext;
    logic signed [DW+1:0]    w_sum;
    logic [DW-1:0]           w_sat;

    // delta = (|a - c| * ((c * (2^DW - c)) >> DW)) >> DW, all unsigned Q0.DW
    function automatic logic [DW-1:0] calc_delta(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] c);
        logic [DW-1:0]   err;
        logic [DW:0]     comp;
        logic [2*DW:0]   sp_prod;
        logic [DW-1:0]   sp;
        logic [2*DW-1:0] d_prod;
        err     = (a >= c) ? (a - c) : (c - a);
        comp    = {1'b1, {DW{1'b0}}} - {1'b0, c};
        sp_prod = (2*DW+1)'(c) * (2*DW+1)'(comp);
        sp      = DW'(sp_prod >> DW);
        d_prod  = (2*DW)'(err) * (2*DW)'(sp);
        return DW'(d_prod >> DW);
    endfunction

    // State register; reset aborts any pass in progress
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        ram_we    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_DELTA;
            end
            S_DELTA: state_nxt = S_READ;
            S_READ:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_WRITE;
            S_WRITE: begin
                ram_we    = 1'b1;
                state_nxt = last_weight ? S_DONE : S_READ;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-neuron error delta from the captured sample
    always_comb begin
        sign_nxt = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            delta_nxt[i] = calc_delta(act_r[i], cal_r[i]);
            sign_nxt[i]  = (act_r[i] < cal_r[i]);
        end
    end

    // Weight address, scaled gradient and saturated new weight
    always_comb begin
        last_weight = (k == KW'(N_OUT - 1)) && (j == JW'(N_HID - 1));
        addr_full   = BASE_ADDR + 32'(k) * N_HID + 32'(j);
        g_prod      = (2*DW)'(delta_r[k]) * (2*DW)'(hid_r[j]);
        g           = DW'((g_prod >> DW) >> LR_SHIFT);
        w_ext       = (DW+2)'($signed(w));
        g_ext       = $signed({2'b00, g});
        w_sum       = delta_sign[k] ? (w_ext - g_ext) : (w_ext + g_ext);
        if (w_sum > SAT_HI) begin
            w_sat = SAT_HI[DW-1:0];
        end else if (w_sum < SAT_LO) begin
            w_sat = SAT_LO[DW-1:0];
        end else begin
            w_sat = w_sum[DW-1:0];
        end
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == S_READ || state == S_WAIT || state == S_WRITE) begin
            ram_addr = ADDR_W'(addr_full);
        end
        if (state == S_WRITE) begin
            ram_wdata = w_sat;
        end
    end

    // Flatten the delta register array onto the output bus
    always_comb begin
        delta_out = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            delta_out[i*DW +: DW] = delta_r[i];
        end
    end

    // Sample capture, delta registers, weight walk counters and read-back
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < N_OUT; i++) begin
                act_r[i]   <= '0;
                cal_r[i]   <= '0;
                delta_r[i] <= '0;
            end
            for (int unsigned i = 0; i < N_HID; i++) begin
                hid_r[i] <= '0;
            end
            delta_sign <= '0;
            k          <= '0;
            j          <= '0;
            w          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < N_OUT; i++) begin
                            act_r[i] <= out_actual[i*DW +: DW];
                            cal_r[i] <= out_cal[i*DW +: DW];
                        end
                        for (int unsigned i = 0; i < N_HID; i++) begin
                            hid_r[i] <= hid_cal[i*DW +: DW];
                        end
                    end
                end
                S_DELTA: begin
                    for (int unsigned i = 0; i < N_OUT; i++) begin
                        delta_r[i] <= delta_nxt[i];
                    end
                    delta_sign <= sign_nxt;
                    k          <= '0;
                    j          <= '0;
                end
                S_WAIT: begin
                    w <= ram_rdata;
                end
                S_WRITE: begin
                    if (j == JW'(N_HID - 1)) begin
                        j <= '0;
                        k <= k + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
